// File: rtl/btn_event_arbiter_pkg.sv
// rtl/btn_event_arbiter_pkg.sv - shared types and helpers for the button event arbiter
// Contents:
//   evt_code_t  : event codes carried on evt_code (press, release, long, repeat)
//   trk_state_t : per-button tracker states
//   cnt_width() : bit width needed to hold 0..maxVal (never less than 1)
package btn_pkg;

    typedef enum logic [1:0] {
        EVT_PRESS   = 2'b00,
        EVT_RELEASE = 2'b01,
        EVT_LONG    = 2'b10,
        EVT_REPEAT  = 2'b11
    } evt_code_t;

    typedef enum logic [1:0] {
        TRK_IDLE = 2'b00,
        TRK_HELD = 2'b01,
        TRK_LONG = 2'b10
    } trk_state_t;

    function automatic int cnt_width(input int maxVal);
        return (maxVal > 0) ? $clog2(maxVal + 1) : 1;
    endfunction

endpackage

// File: rtl/btn_event_arbiter_if.sv
// rtl/btn_event_arbiter_if.sv - event output handshake bundle of the button event arbiter
// Signals:
//   evt_valid : event presented (master -> slave)
//   evt_ready : consumer accepts the event (slave -> master)
//   evt_btn   : index of the button that produced the event, $clog2(NUM_BTNS) bits
//   evt_code  : 00 press, 01 release, 10 long, 11 repeat
//   overflow  : one-cycle pulse when a pending event is overwritten
// Modports: master (arbiter side), slave (consumer side)
interface btn_event_arbiter_if #(
    parameter int NUM_BTNS = 4
);
    localparam int BTN_W = $clog2(NUM_BTNS);

    logic             evt_valid;
    logic             evt_ready;
    logic [BTN_W-1:0] evt_btn;
    logic [1:0]       evt_code;
    logic             overflow;

    modport master (
        output evt_valid,
        output evt_btn,
        output evt_code,
        output overflow,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_btn,
        input  evt_code,
        input  overflow,
        output evt_ready
    );
endinterface

// File: rtl/btn_event_arbiter_tracker.sv
// rtl/btn_event_arbiter_tracker.sv - one button's press/long/repeat tracker with a one-deep pending slot
// Optional feature: BTN_AUTOREPEAT_EN (repeat events while held in LONG).
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   msTick     : one-cycle millisecond strobe from the shared prescaler
//   btnLevel   : debounced level of this button, 1 = pressed
//   grant      : the arbiter takes this button's pending event this cycle
//   pending    : a pending event is waiting
//   pendCode   : code of the pending event
//   overwrite  : a new event replaces an ungranted pending event this cycle
module btn_event_tracker
    import btn_pkg::*;
#(
    parameter int LONG_PRESS_MS = 500,
    parameter int REPEAT_MS     = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       msTick,
    input  logic       btnLevel,
    input  logic       grant,
    output logic       pending,
    output logic [1:0] pendCode,
    output logic       overwrite
);
    localparam int HOLD_MAX = (LONG_PRESS_MS > REPEAT_MS) ? LONG_PRESS_MS : REPEAT_MS;
    localparam int HOLD_W   = cnt_width(HOLD_MAX);
    localparam logic [HOLD_W-1:0] LONG_LIMIT = HOLD_W'(LONG_PRESS_MS);
`ifdef BTN_AUTOREPEAT_EN
    localparam logic [HOLD_W-1:0] REPEAT_LIMIT = HOLD_W'(REPEAT_MS);
`endif

    localparam logic [1:0] ST_IDLE = TRK_IDLE;
    localparam logic [1:0] ST_HELD = TRK_HELD;
    localparam logic [1:0] ST_LONG = TRK_LONG;

    logic [1:0]        state, stateNext;
    logic [HOLD_W-1:0] holdCnt, holdNext;
    logic              prevLevel;
    logic              rise, fall;
    logic              gen;
    logic [1:0]        genCode;

    assign rise = btnLevel & ~prevLevel;
    assign fall = ~btnLevel & prevLevel;

    // Edges are checked before the tick so that an edge landing on a tick
    // cycle wins and the counter step is dropped.
    always_comb begin
        stateNext = state;
        holdNext  = holdCnt;
        gen       = 1'b0;
        genCode   = EVT_PRESS;
        case (state)
            ST_IDLE: begin
                if (rise) begin
                    gen       = 1'b1;
                    genCode   = EVT_PRESS;
                    stateNext = ST_HELD;
                    holdNext  = '0;
                end
            end
            ST_HELD: begin
                if (fall) begin
                    gen       = 1'b1;
                    genCode   = EVT_RELEASE;
                    stateNext = ST_IDLE;
                    holdNext  = '0;
                end else if (holdCnt == LONG_LIMIT) begin
                    gen       = 1'b1;
                    genCode   = EVT_LONG;
                    stateNext = ST_LONG;
                    holdNext  = '0;
                end else if (msTick) begin
                    holdNext = holdCnt + HOLD_W'(1);
                end
            end
            ST_LONG: begin
                if (fall) begin
                    gen       = 1'b1;
                    genCode   = EVT_RELEASE;
                    stateNext = ST_IDLE;
                    holdNext  = '0;
                end
`ifdef BTN_AUTOREPEAT_EN
                else if (holdCnt == REPEAT_LIMIT) begin
                    gen      = 1'b1;
                    genCode  = EVT_REPEAT;
                    holdNext = '0;
                end else if (msTick) begin
                    holdNext = holdCnt + HOLD_W'(1);
                end
`endif
            end
            default: begin
                stateNext = ST_IDLE;
                holdNext  = '0;
            end
        endcase
    end

    // A grant in the same cycle as a new event only retires the old one;
    // the new event stays pending and is not an overwrite.
    assign overwrite = gen & pending & ~grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            holdCnt   <= '0;
            prevLevel <= 1'b0;
            pending   <= 1'b0;
            pendCode  <= EVT_PRESS;
        end else begin
            state     <= stateNext;
            holdCnt   <= holdNext;
            prevLevel <= btnLevel;
            if (gen) begin
                pending  <= 1'b1;
                pendCode <= genCode;
            end else if (grant) begin
                pending <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/btn_event_arbiter.sv
// rtl/btn_event_arbiter.sv - per-button event trackers with round-robin arbitration onto one event stream
// Optional feature: define BTN_AUTOREPEAT_EN to emit repeat events while a button stays in long-press.
// Ports:
//   clk       : clock
//   reset     : synchronous, active-high reset
//   btn_level : NUM_BTNS debounced clk-synchronous levels, 1 = pressed
//   evt       : btn_event_arbiter_if.master (evt_valid/evt_ready/evt_btn/evt_code/overflow)
module btn_event_arbiter
    import btn_pkg::*;
#(
    parameter int NUM_BTNS      = 4,
    parameter int CLKIN_FREQ    = 27_000_000,
    parameter int LONG_PRESS_MS = 500,
    parameter int REPEAT_MS     = 100
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_BTNS-1:0] btn_level,
    btn_event_arbiter_if.master evt
);
    localparam int BTN_W     = $clog2(NUM_BTNS);
    localparam int PRESC_MAX = CLKIN_FREQ / 1000 - 1;
    localparam int PRESC_W   = cnt_width(PRESC_MAX);

    logic [PRESC_W-1:0]    prescaler;
    logic                  msTick;
    logic [NUM_BTNS-1:0]   pendVec;
    logic [NUM_BTNS-1:0]   ovfVec;
    logic [NUM_BTNS-1:0]   grantVec;
    logic [1:0]            pendCode [NUM_BTNS];
    logic [BTN_W-1:0]      lastGrant;
    logic [BTN_W-1:0]      nextIdx;
    logic                  found;
    logic                  loadEn;
    logic [2*NUM_BTNS-1:0] doubled;
    logic [NUM_BTNS-1:0]   rotated;

    assign msTick = (prescaler == PRESC_W'(PRESC_MAX));

    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_trk
        btn_event_tracker #(
            .LONG_PRESS_MS(LONG_PRESS_MS),
            .REPEAT_MS    (REPEAT_MS)
        ) u_trk (
            .clk      (clk),
            .reset    (reset),
            .msTick   (msTick),
            .btnLevel (btn_level[g]),
            .grant    (grantVec[g]),
            .pending  (pendVec[g]),
            .pendCode (pendCode[g]),
            .overwrite(ovfVec[g])
        );
    end

    assign loadEn = ~evt.evt_valid | evt.evt_ready;

    // Rotate the pending vector so bit 0 is the index just above the last
    // grant; the lowest set bit of the rotated vector is the next winner.
    always_comb begin
        int sum;
        found   = 1'b0;
        nextIdx = '0;
        sum     = 0;
        doubled = {pendVec, pendVec};
        rotated = NUM_BTNS'(doubled >> (int'(lastGrant) + 1));
        for (int i = 0; i < NUM_BTNS; i++) begin
            if (!found && rotated[i]) begin
                found = 1'b1;
                sum   = int'(lastGrant) + 1 + i;
                if (sum >= NUM_BTNS) sum = sum - NUM_BTNS;
                nextIdx = BTN_W'(sum);
            end
        end
    end

    always_comb begin
        grantVec = '0;
        if (loadEn && found) grantVec[nextIdx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler     <= '0;
            lastGrant     <= '0;
            evt.evt_valid <= 1'b0;
            evt.evt_btn   <= '0;
            evt.evt_code  <= EVT_PRESS;
            evt.overflow  <= 1'b0;
        end else begin
            prescaler    <= msTick ? '0 : prescaler + PRESC_W'(1);
            evt.overflow <= |ovfVec;
            if (loadEn) begin
                if (found) begin
                    evt.evt_valid <= 1'b1;
                    evt.evt_btn   <= nextIdx;
                    evt.evt_code  <= pendCode[nextIdx];
                    lastGrant     <= nextIdx;
                end else begin
                    evt.evt_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_btn_event_arbiter.sv
// tb/tb_btn_event_arbiter.sv - directed self-checking bench for btn_event_arbiter
module tb_btn_event_arbiter;
    logic       clk;
    logic       reset;
    logic [3:0] btnLevel;

    btn_event_arbiter_if #(.NUM_BTNS(4)) evt ();

    btn_event_arbiter #(
        .NUM_BTNS     (4),
        .CLKIN_FREQ   (10_000),
        .LONG_PRESS_MS(5),
        .REPEAT_MS    (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_level(btnLevel),
        .evt      (evt.master)
    );

    typedef struct {
        int btn;
        int code;
        int cyc;
    } ev_t;

    ev_t evQ[$];
    int  checks     = 0;
    int  failures   = 0;
    int  cycleCnt   = 0;
    int  ovfCnt     = 0;
    int  repeatSeen = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Sampled just after the falling edge, once the bench has set its inputs
    // for the coming rising edge, so valid&ready here is the real handshake.
    always @(negedge clk) begin
        #2;
        if (!reset) begin
            if (evt.evt_valid && evt.evt_ready) begin
                evQ.push_back('{btn: int'(evt.evt_btn), code: int'(evt.evt_code), cyc: cycleCnt});
                if (evt.evt_code == 2'b11) repeatSeen++;
            end
            if (evt.overflow) ovfCnt++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic checkOut(input string tag, input logic v, input int b, input int c);
        check({tag, "_valid"}, 32'(evt.evt_valid), 32'(v));
        check({tag, "_btn"}, 32'(evt.evt_btn), 32'(b));
        check({tag, "_code"}, 32'(evt.evt_code), 32'(c));
    endtask

    initial begin
        int n;
        reset         = 1'b1;
        btnLevel      = 4'h0;
        evt.evt_ready = 1'b1;

        // reset state
        cyc(3);
        checkOut("rst", 1'b0, 0, 0);
        check("rst_ovf", 32'(evt.overflow), 0);
        reset = 1'b0;
        cyc(3);

        // single press/release latency on button 2
        btnLevel = 4'b0100;
        cyc(1);
        check("lat_n1_valid", 32'(evt.evt_valid), 0);
        cyc(1);
        checkOut("lat_press", 1'b1, 2, 0);
        cyc(1);
        check("lat_drain", 32'(evt.evt_valid), 0);
        btnLevel = 4'b0000;
        cyc(1);
        check("rel_n1_valid", 32'(evt.evt_valid), 0);
        cyc(1);
        checkOut("lat_release", 1'b1, 2, 1);
        cyc(4);

        // hold button 1 for 80 cycles
        evQ.delete();
        btnLevel = 4'b0010;
        cyc(80);
        btnLevel = 4'b0000;
        cyc(5);
        n = evQ.size();
        check("hold_first_btn", 32'(evQ[0].btn), 1);
        check("hold_first_code", 32'(evQ[0].code), 0);
        check("hold_long_code", 32'(evQ[1].code), 2);
        check("hold_long_win", 32'((evQ[1].cyc - evQ[0].cyc >= 40) && (evQ[1].cyc - evQ[0].cyc <= 56)), 1);
        check("hold_last_code", 32'(evQ[n-1].code), 1);
`ifdef BTN_AUTOREPEAT_EN
        check("hold_count", 32'(n >= 4), 1);
        check("hold_rep_code", 32'(evQ[2].code), 3);
        check("hold_rep_win", 32'((evQ[2].cyc - evQ[1].cyc >= 15) && (evQ[2].cyc - evQ[1].cyc <= 25)), 1);
`else
        check("hold_count", 32'(n), 3);
`endif

        // round robin: make button 3 the last grant, then press all four
        btnLevel = 4'b1000;
        cyc(4);
        btnLevel = 4'b0000;
        cyc(5);
        evQ.delete();
        btnLevel = 4'b1111;
        cyc(7);
        check("rr_count", 32'(evQ.size()), 4);
        for (int i = 0; i < 4; i++) begin
            check("rr_btn", 32'(evQ[i].btn), 32'(i));
            check("rr_cyc", 32'(evQ[i].cyc - evQ[0].cyc), 32'(i));
        end
        btnLevel = 4'b0000;
        cyc(7);
        btnLevel = 4'b0010;
        cyc(4);
        btnLevel = 4'b0000;
        cyc(5);
        evQ.delete();
        btnLevel = 4'b1101;
        cyc(7);
        check("rr2_count", 32'(evQ.size()), 3);
        check("rr2_btn0", 32'(evQ[0].btn), 2);
        check("rr2_btn1", 32'(evQ[1].btn), 3);
        check("rr2_btn2", 32'(evQ[2].btn), 0);
        btnLevel = 4'b0000;
        cyc(7);

        // overflow while the output is stalled
        evQ.delete();
        ovfCnt        = 0;
        evt.evt_ready = 1'b0;
        btnLevel      = 4'b0100;
        cyc(3);
        checkOut("stall_a", 1'b1, 2, 0);
        btnLevel = 4'b0101;
        cyc(2);
        checkOut("stall_b", 1'b1, 2, 0);
        btnLevel = 4'b0100;
        cyc(3);
        checkOut("stall_c", 1'b1, 2, 0);
        check("ovf_count", 32'(ovfCnt), 1);
        evt.evt_ready = 1'b1;
        cyc(4);
        check("ovf_q_count", 32'(evQ.size()), 2);
        check("ovf_q0_btn", 32'(evQ[0].btn), 2);
        check("ovf_q1_btn", 32'(evQ[1].btn), 0);
        check("ovf_q1_code", 32'(evQ[1].code), 1);
        btnLevel = 4'b0000;
        cyc(5);

        // reset in the middle of a stalled handshake, button 1 held throughout
        evt.evt_ready = 1'b0;
        btnLevel      = 4'b0010;
        cyc(3);
        checkOut("pre_rst", 1'b1, 1, 0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            checkOut("in_rst", 1'b0, 0, 0);
            check("in_rst_ovf", 32'(evt.overflow), 0);
        end
        reset         = 1'b0;
        evt.evt_ready = 1'b1;
        cyc(1);
        check("post_rst_n1", 32'(evt.evt_valid), 0);
        cyc(1);
        checkOut("post_rst_press", 1'b1, 1, 0);
        btnLevel = 4'b0000;
        cyc(5);

`ifndef BTN_AUTOREPEAT_EN
        check("no_repeat_code", 32'(repeatSeen), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
